// File: rtl/gsm_msg_scheduler.sv
// gsm_msg_scheduler: shares one GSM transmitter among three message sources.
// Requests are single-cycle pulses with a payload snapshot (latest wins per source).
// Pending sources are granted by fixed priority (2 > 1 > 0). Each SMS goes through
// send / wait-for-ack with nack and timeout retries. A minimum idle gap follows
// every completed or dropped message.
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   req[2:0], req_data      request pulses and per-source payload slices
//   gsm_busy/ack/nack       modem status inputs
//   gsm_send                one-cycle transmit strobe
//   gsm_payload, gsm_tag    payload and source id of the current message
//   done, fail              one-cycle completion / drop pulses
//   pending[2:0]            per-source pending flags
module gsm_msg_scheduler #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned MIN_GAP   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [3*DATA_W-1:0]   req_data,
    input  logic                  gsm_busy,
    input  logic                  gsm_ack,
    input  logic                  gsm_nack,
    output logic                  gsm_send,
    output logic [DATA_W-1:0]     gsm_payload,
    output logic [1:0]            gsm_tag,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            pending
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned ATT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    // Gap counter only ever holds MIN_GAP-1 down to 0.
    localparam int unsigned GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          pending_q, pending_d;
    logic [DATA_W-1:0]   data_q [3];
    logic [DATA_W-1:0]   data_d [3];
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic [1:0]          tag_q, tag_d;
    logic                send_q, send_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ATT_W-1:0]    att_q, att_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [1:0]          grant_idx;
    logic [DATA_W-1:0]   grant_data;

    // Next-state, capture and output logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        data_d     = data_q;
        payload_d  = payload_q;
        tag_d      = tag_q;
        send_d     = 1'b0;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        tmo_d      = tmo_q;
        att_d      = att_q;
        gap_d      = gap_q;
        grant_idx  = 2'd0;
        grant_data = data_q[0];

        if (pending_q[2]) begin
            grant_idx  = 2'd2;
            grant_data = data_q[2];
        end else if (pending_q[1]) begin
            grant_idx  = 2'd1;
            grant_data = data_q[1];
        end

        case (state_q)
            S_IDLE: begin
                if ((|pending_q) && !gsm_busy) begin
                    payload_d            = grant_data;
                    tag_d                = grant_idx;
                    pending_d[grant_idx] = 1'b0;
                    att_d                = '0;
                    send_d               = 1'b1;
                    state_d              = S_SEND;
                end
            end
            S_SEND: begin
                // Send-to-resend period is TIMEOUT cycles: TIMEOUT-1 of them in WAIT_ACK.
                tmo_d   = TMO_W'(TIMEOUT - 1);
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tmo_d = (tmo_q != '0) ? (tmo_q - TMO_W'(1)) : '0;
                if (gsm_ack) begin
                    done_d  = 1'b1;
                    gap_d   = GAP_W'(MIN_GAP - 1);
                    state_d = S_GAP;
                end else if (gsm_nack || (tmo_q <= TMO_W'(1))) begin
                    if (att_q < ATT_W'(RETRY_MAX)) begin
                        att_d   = att_q + ATT_W'(1);
                        send_d  = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        fail_d  = 1'b1;
                        gap_d   = GAP_W'(MIN_GAP - 1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new request overrides the grant clear so a same-edge repeat stays pending.
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                pending_d[i] = 1'b1;
                data_d[i]    = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
            payload_q <= '0;
            tag_q     <= '0;
            send_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= '0;
            att_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            payload_q <= payload_d;
            tag_q     <= tag_d;
            send_q    <= send_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
            att_q     <= att_d;
            gap_q     <= gap_d;
        end
    end

    assign gsm_send    = send_q;
    assign gsm_payload = payload_q;
    assign gsm_tag     = tag_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign pending     = pending_q;

endmodule
